// File: rtl/spram_rr_ctrl_pkg.sv
// Shared definitions for the single-port RAM round-robin controller.
// Holds the default RAM geometry (also used by the RAM benches) and the
// arbiter state encoding.
package spram_rr_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  // Arbiter ownership state. Encodings are fixed because other benches
  // decode them directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spram_rr_ctrl_arb.sv
// rr_burst_arb2: two-input round-robin arbiter with a bounded burst lock.
// Ports:
//   clock, reset_n   : clock and synchronous active-low reset
//   req0, req1       : access requests
//   gnt0, gnt1       : combinational one-hot (or zero) grants
//   state            : current ownership state, exported for observation
// The owner keeps the grant while it keeps requesting, until it has taken
// MAX_BURST consecutive grants with the other side waiting; a lone
// requester is never throttled.
module rr_burst_arb2
  import spram_rr_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output arb_state_t state
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  arb_state_t    state_next;
  logic [CW-1:0] burst_cnt, burst_cnt_next;
  logic          last_served, last_served_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;  // requester 0 wins the first tie
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_cnt_next;
      last_served <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state;
    burst_cnt_next   = burst_cnt;
    last_served_next = last_served;
    gnt0             = 1'b0;
    gnt1             = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (req0 && (!req1 || last_served)) begin
          gnt0 = 1'b1; state_next = ST_OWN0; burst_cnt_next = ONE_CNT; last_served_next = 1'b0;
        end else if (req1) begin
          gnt1 = 1'b1; state_next = ST_OWN1; burst_cnt_next = ONE_CNT; last_served_next = 1'b1;
        end
      end
      ST_OWN0: begin
        if (req0 && (burst_cnt < MAX_CNT || !req1)) begin
          gnt0 = 1'b1;
          burst_cnt_next = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + ONE_CNT;
        end else if (req1) begin
          gnt1 = 1'b1; state_next = ST_OWN1; burst_cnt_next = ONE_CNT; last_served_next = 1'b1;
        end else begin
          state_next = ST_IDLE; burst_cnt_next = '0;
        end
      end
      ST_OWN1: begin
        if (req1 && (burst_cnt < MAX_CNT || !req0)) begin
          gnt1 = 1'b1;
          burst_cnt_next = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + ONE_CNT;
        end else if (req0) begin
          gnt0 = 1'b1; state_next = ST_OWN0; burst_cnt_next = ONE_CNT; last_served_next = 1'b0;
        end else begin
          state_next = ST_IDLE; burst_cnt_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE; burst_cnt_next = '0;
      end
    endcase

    // No access may be accepted on a reset edge.
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/spram_rr_ctrl.sv
// spram_rr_ctrl: shares one external single-port RAM between two requesters.
// Ports:
//   clock, reset_n                  : clock and synchronous active-low reset
//   reqX/weX/addrX/wdataX           : requester X access (we=1 write, 0 read)
//   gntX                            : access accepted this cycle
//   rvalidX/rdataX                  : read result, one cycle after a read grant
//   ram_we/ram_addr/ram_data        : drive the RAM port
//   ram_out                         : RAM synchronous read data
//   arb_state                       : arbiter state, for observation
// Handshake: a requester holds req/we/addr/wdata stable until gnt is high;
// the access is consumed on the posedge where gnt=1, and the requester may
// drop req or present a new access in the following cycle. gnt is purely
// combinational from req and arbiter state.
module spram_rr_ctrl
  import spram_rr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output arb_state_t            arb_state
);

  rr_burst_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .state   (arb_state)
  );

  // Grants are already forced low in reset, so the idle value covers reset too.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (gnt0) begin
      ram_we = we0; ram_addr = addr0; ram_data = wdata0;
    end else if (gnt1) begin
      ram_we = we1; ram_addr = addr1; ram_data = wdata1;
    end
  end

  // RAM read data lands one edge after the grant, in step with these flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  assign rdata0 = ram_out;
  assign rdata1 = ram_out;

endmodule

// File: tb/tb_spram_rr_ctrl.sv
// Bench for spram_rr_ctrl: two instances share one stimulus stream,
// instance a with MAX_BURST=4 and instance b with MAX_BURST=1, each with
// its own behavioural RAM.
module tb_spram_rr_ctrl;
  import spram_rr_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_we_a;
  logic [DW-1:0] rdata0_a, rdata1_a, ram_data_a, ram_out_a;
  logic [AW-1:0] ram_addr_a;
  arb_state_t    state_a;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_we_b;
  logic [DW-1:0] rdata0_b, rdata1_b, ram_data_b, ram_out_b;
  logic [AW-1:0] ram_addr_b;
  arb_state_t    state_b;

  spram_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .ram_out(ram_out_a), .arb_state(state_a)
  );

  spram_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .ram_out(ram_out_b), .arb_state(state_b)
  );

  // Behavioural single-port RAMs: synchronous read of the old contents.
  logic [DW-1:0] mem_a [2**AW];
  logic [DW-1:0] mem_b [2**AW];
  always @(posedge clock) begin
    if (ram_we_a) mem_a[ram_addr_a] <= ram_data_a;
    ram_out_a <= mem_a[ram_addr_a];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_data_b;
    ram_out_b <= mem_b[ram_addr_b];
  end

  // scoreboard: shadow memories and expected read-data queues
  logic [DW-1:0] sh_a [2**AW];
  logic [DW-1:0] sh_b [2**AW];
  logic [DW-1:0] exp_q_a0[$];
  logic [DW-1:0] exp_q_a1[$];
  logic [DW-1:0] exp_q_b0[$];
  logic [DW-1:0] exp_q_b1[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic rv_check(input string tag, input logic rv, input logic [DW-1:0] rd,
                          input logic has_exp, input logic [DW-1:0] exp_data);
    chk({tag, ".rvalid"}, {31'd0, rv}, {31'd0, has_exp});
    if (has_exp) chk({tag, ".rdata"}, {16'd0, rd}, {16'd0, exp_data});
  endtask

  // e: expected grant, 1 = requester 0, 2 = requester 1, 0 = none
  task automatic port_check(input string tag, input logic [1:0] e, input logic g0, input logic g1,
                            input logic rwe, input logic [AW-1:0] raddr, input logic [DW-1:0] rdat);
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    x_we = 1'b0; x_addr = '0; x_data = '0;
    if (e == 2'd1) begin x_we = we0; x_addr = addr0; x_data = wdata0; end
    if (e == 2'd2) begin x_we = we1; x_addr = addr1; x_data = wdata1; end
    chk({tag, ".gnt0"}, {31'd0, g0}, {31'd0, e == 2'd1});
    chk({tag, ".gnt1"}, {31'd0, g1}, {31'd0, e == 2'd2});
    chk({tag, ".ram_we"}, {31'd0, rwe}, {31'd0, x_we});
    chk({tag, ".ram_addr"}, {24'd0, raddr}, {24'd0, x_addr});
    chk({tag, ".ram_data"}, {16'd0, rdat}, {16'd0, x_data});
  endtask

  // driver: one clock cycle of stimulus with expected grants for a and b
  task automatic step(input logic rn,
                      input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [1:0] ea, input logic [1:0] eb);
    @(posedge clock);
    #1;
    if (exp_q_a0.size() != 0) rv_check("a0", rvalid0_a, rdata0_a, 1'b1, exp_q_a0.pop_front());
    else                      rv_check("a0", rvalid0_a, rdata0_a, 1'b0, '0);
    if (exp_q_a1.size() != 0) rv_check("a1", rvalid1_a, rdata1_a, 1'b1, exp_q_a1.pop_front());
    else                      rv_check("a1", rvalid1_a, rdata1_a, 1'b0, '0);
    if (exp_q_b0.size() != 0) rv_check("b0", rvalid0_b, rdata0_b, 1'b1, exp_q_b0.pop_front());
    else                      rv_check("b0", rvalid0_b, rdata0_b, 1'b0, '0);
    if (exp_q_b1.size() != 0) rv_check("b1", rvalid1_b, rdata1_b, 1'b1, exp_q_b1.pop_front());
    else                      rv_check("b1", rvalid1_b, rdata1_b, 1'b0, '0);

    reset_n = rn;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #2;
    port_check("a", ea, gnt0_a, gnt1_a, ram_we_a, ram_addr_a, ram_data_a);
    port_check("b", eb, gnt0_b, gnt1_b, ram_we_b, ram_addr_b, ram_data_b);

    if (ea == 2'd1) begin if (w0) sh_a[a0] = d0; else exp_q_a0.push_back(sh_a[a0]); end
    if (ea == 2'd2) begin if (w1) sh_a[a1] = d1; else exp_q_a1.push_back(sh_a[a1]); end
    if (eb == 2'd1) begin if (w0) sh_b[a0] = d0; else exp_q_b0.push_back(sh_b[a0]); end
    if (eb == 2'd2) begin if (w1) sh_b[a1] = d1; else exp_q_b1.push_back(sh_b[a1]); end
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 2**AW; i++) begin
      mem_a[i] = 16'h5A00 | 16'(i); sh_a[i] = 16'h5A00 | 16'(i);
      mem_b[i] = 16'h5A00 | 16'(i); sh_b[i] = 16'h5A00 | 16'(i);
    end

    // reset held with both requesting: no grants, RAM port idle
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 8'h30, '0, 1'b1, 1'b0, 8'h31, '0, 2'd0, 2'd0);
    chk("a.state_in_reset", {30'd0, state_a}, {30'd0, ST_IDLE});

    // contention from reset: a grants 0x4,1x4,..., b alternates
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b0, 8'h30, '0, 1'b1, 1'b0, 8'h31, '0,
           (((i / 4) % 2) != 0) ? 2'd2 : 2'd1, ((i % 2) != 0) ? 2'd2 : 2'd1);
    idle_step();

    // lone requester 1 is never throttled
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h40 + 8'(i), '0, 2'd2, 2'd2);
    idle_step();

    // single writer then reader
    step(1'b1, 1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0, 1'b0, '0, '0, 2'd1, 2'd1);
    step(1'b1, 1'b1, 1'b0, 8'h05, '0,       1'b0, 1'b0, '0, '0, 2'd1, 2'd1);
    idle_step();

    // preload for interleaved reads
    step(1'b1, 1'b1, 1'b1, 8'h10, 16'h1111, 1'b0, 1'b0, '0, '0, 2'd1, 2'd1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h20, 16'h2222, 2'd2, 2'd2);
    idle_step();

    // interleaved reads: last served was 1, so 0 goes first
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 8'h20, '0,
           (i < 4) ? 2'd1 : 2'd2, ((i % 2) != 0) ? 2'd2 : 2'd1);
    idle_step();

    // reset arriving on the edge after a read grant
    step(1'b1, 1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0, '0, '0, 2'd1, 2'd1);
    step(1'b0, 1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
    // first cycle out of reset: tie must go to requester 0 again
    step(1'b1, 1'b1, 1'b0, 8'h05, '0, 1'b1, 1'b0, 8'h06, '0, 2'd1, 2'd1);
    chk("a.state_after_reset_grant", {30'd0, state_a}, {30'd0, ST_IDLE});
    chk("b.state_after_reset_grant", {30'd0, state_b}, {30'd0, ST_IDLE});
    idle_step();
    idle_step();

    chk("a0.q_empty", exp_q_a0.size(), 0);
    chk("a1.q_empty", exp_q_a1.size(), 0);
    chk("b0.q_empty", exp_q_b0.size(), 0);
    chk("b1.q_empty", exp_q_b1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
